// File: rtl/seq_select_ctrl.sv
// Sequence-select controller: debounced up/down buttons step the sequence index,
// a slow tick advances the step within it, and both drive the pattern ROM address and LEDs.
module seq_select_ctrl #(
  parameter int SEQ_W   = 3,
  parameter int N_SEQ   = 8,
  parameter int STEP_W  = 4,
  parameter int SEQ_LEN = 16,
  parameter int DEB_LEN = 8,
  parameter int WRAP    = 1
) (
  input  logic                    clk_50,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic                    step_tick,
  input  logic                    pb_seq_up,
  input  logic                    pb_seq_dn,
  output logic [SEQ_W-1:0]        seq_num,
  output logic [STEP_W-1:0]       step,
  output logic [SEQ_W+STEP_W-1:0] ROM_addr,
  output logic [N_SEQ-1:0]        LEDS,
  output logic                    seq_changed
);

  localparam int                AW       = SEQ_W + STEP_W;
  localparam logic [SEQ_W-1:0]  SEQ_MAX  = SEQ_W'(N_SEQ - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(SEQ_LEN - 1);

  logic [1:0]         up_sync_r, dn_sync_r;
  logic [DEB_LEN-1:0] up_sh_r, dn_sh_r;
  logic [DEB_LEN-1:0] up_sh_next_s, dn_sh_next_s;
  logic               up_deb_r, dn_deb_r, up_deb_q_r, dn_deb_q_r;
  logic               up_press_s, dn_press_s;
  logic [SEQ_W-1:0]   seq_next_s;
  logic               seq_chg_s;

  assign up_sh_next_s = {up_sh_r[DEB_LEN-2:0], up_sync_r[1]};
  assign dn_sh_next_s = {dn_sh_r[DEB_LEN-2:0], dn_sync_r[1]};
  assign up_press_s   = up_deb_r & ~up_deb_q_r;
  assign dn_press_s   = dn_deb_r & ~dn_deb_q_r;

  // Synchronisers, debounce windows (judged on the post-shift contents) and press-edge history
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      up_sync_r  <= 2'b00;
      dn_sync_r  <= 2'b00;
      up_sh_r    <= {DEB_LEN{1'b0}};
      dn_sh_r    <= {DEB_LEN{1'b0}};
      up_deb_r   <= 1'b0;
      dn_deb_r   <= 1'b0;
      up_deb_q_r <= 1'b0;
      dn_deb_q_r <= 1'b0;
    end else begin
      up_sync_r  <= {up_sync_r[0], pb_seq_up};
      dn_sync_r  <= {dn_sync_r[0], pb_seq_dn};
      up_deb_q_r <= up_deb_r;
      dn_deb_q_r <= dn_deb_r;
      if (sample_tick) begin
        up_sh_r <= up_sh_next_s;
        dn_sh_r <= dn_sh_next_s;
        if (&up_sh_next_s)       up_deb_r <= 1'b1;
        else if (~|up_sh_next_s) up_deb_r <= 1'b0;
        else                     up_deb_r <= up_deb_r;
        if (&dn_sh_next_s)       dn_deb_r <= 1'b1;
        else if (~|dn_sh_next_s) dn_deb_r <= 1'b0;
        else                     dn_deb_r <= dn_deb_r;
      end else begin
        up_sh_r <= up_sh_r;
        dn_sh_r <= dn_sh_r;
      end
    end
  end

  // Next sequence index; coincident presses cancel, and a saturated hold is not a change
  always_comb begin
    seq_next_s = seq_num;
    if (up_press_s && !dn_press_s) begin
      if (seq_num == SEQ_MAX) begin
        if (WRAP != 0) seq_next_s = {SEQ_W{1'b0}};
        else           seq_next_s = seq_num;
      end else begin
        seq_next_s = seq_num + SEQ_W'(1);
      end
    end else if (dn_press_s && !up_press_s) begin
      if (seq_num == {SEQ_W{1'b0}}) begin
        if (WRAP != 0) seq_next_s = SEQ_MAX;
        else           seq_next_s = seq_num;
      end else begin
        seq_next_s = seq_num - SEQ_W'(1);
      end
    end else begin
      seq_next_s = seq_num;
    end
  end

  assign seq_chg_s = (seq_next_s != seq_num);

  // Sequence index, step counter (cleared by a sequence change ahead of step_tick) and change pulse
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      seq_num     <= {SEQ_W{1'b0}};
      step        <= {STEP_W{1'b0}};
      seq_changed <= 1'b0;
    end else begin
      seq_num     <= seq_next_s;
      seq_changed <= seq_chg_s;
      if (seq_chg_s)                 step <= {STEP_W{1'b0}};
      else if (step_tick) begin
        if (step == STEP_MAX)        step <= {STEP_W{1'b0}};
        else                         step <= step + STEP_W'(1);
      end else                       step <= step;
    end
  end

  assign ROM_addr = AW'(seq_num) * AW'(SEQ_LEN) + AW'(step);
  assign LEDS     = {{(N_SEQ-1){1'b0}}, 1'b1} << seq_num;

endmodule

// File: tb/tb_seq_select_ctrl.sv
// Bench for seq_select_ctrl: a wrapping instance driven through press/bounce/step scenarios,
// plus a saturating instance; expected sequence values are queued and matched on seq_changed.
module tb_seq_select_ctrl;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0, step_tick = 1'b0;
  logic       pb_seq_up = 1'b0, pb_seq_dn = 1'b0;
  logic       pb_up2 = 1'b0, pb_dn2 = 1'b0;
  logic [2:0] seq_num, seq_num2;
  logic [3:0] step, step2;
  logic [6:0] ROM_addr, ROM_addr2;
  logic [7:0] LEDS, LEDS2;
  logic       seq_changed, seq_changed2;

  int total_cnt = 0, bad_cnt = 0;
  int exp_q[$];
  int n_push = 0, pulse1 = 0, pulse2 = 0;
  int exp_seq = 0, exp_step = 0, exp_step2 = 0;

  seq_select_ctrl #(.WRAP(1)) dut (
    .clk_50(clk_50), .reset(reset), .sample_tick(sample_tick), .step_tick(step_tick),
    .pb_seq_up(pb_seq_up), .pb_seq_dn(pb_seq_dn), .seq_num(seq_num), .step(step),
    .ROM_addr(ROM_addr), .LEDS(LEDS), .seq_changed(seq_changed));

  seq_select_ctrl #(.WRAP(0)) dut_sat (
    .clk_50(clk_50), .reset(reset), .sample_tick(sample_tick), .step_tick(step_tick),
    .pb_seq_up(pb_up2), .pb_seq_dn(pb_dn2), .seq_num(seq_num2), .step(step2),
    .ROM_addr(ROM_addr2), .LEDS(LEDS2), .seq_changed(seq_changed2));

  always #5 clk_50 = ~clk_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every change pulse must match the oldest queued expectation
  always @(negedge clk_50) begin
    if (seq_changed) begin
      pulse1++;
      if (exp_q.size() == 0) check_val("pulse_expected", exp_q.size(), 1);
      else begin
        int e;
        e = exp_q.pop_front();
        check_val("seq_on_pulse", seq_num, e);
        check_val("leds_on_pulse", LEDS, 1 << e);
      end
    end
    if (seq_changed2) pulse2++;
  end

  task automatic stick();
    @(negedge clk_50) sample_tick = 1'b1;
    @(negedge clk_50) sample_tick = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask

  task automatic sticks(input int n);
    for (int i = 0; i < n; i++) stick();
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_50);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50) step_tick = 1'b1;
      @(negedge clk_50) step_tick = 1'b0;
      exp_step  = (exp_step + 1) % 16;
      exp_step2 = (exp_step2 + 1) % 16;
    end
  endtask

  function automatic int model_next(input bit up, input bit dn, input int cur);
    if (up && !dn) return (cur == 7) ? 0 : cur + 1;
    else if (dn && !up) return (cur == 0) ? 7 : cur - 1;
    else return cur;
  endfunction

  task automatic check_outs(input string tag);
    check_val({tag, "_seq"}, seq_num, exp_seq);
    check_val({tag, "_step"}, step, exp_step);
    check_val({tag, "_rom"}, ROM_addr, exp_seq * 16 + exp_step);
    check_val({tag, "_leds"}, LEDS, 1 << exp_seq);
  endtask

  task automatic release_all();
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
    settle();
    sticks(8);
  endtask

  // Hold the buttons for a full qualification window, then release them cleanly
  task automatic press(input bit up, input bit dn);
    int nxt;
    pb_seq_up = up;
    pb_seq_dn = dn;
    nxt = model_next(up, dn, exp_seq);
    if (nxt != exp_seq) begin exp_q.push_back(nxt); n_push++; end
    settle();
    sticks(7);
    check_val("no_early_change", seq_num, exp_seq);
    stick();
    if (nxt != exp_seq) begin exp_seq = nxt; exp_step = 0; end
    check_outs("press");
    release_all();
  endtask

  initial begin
    // Reset with both buttons held
    pb_seq_up = 1'b1;
    pb_seq_dn = 1'b1;
    repeat (4) @(negedge clk_50);
    check_outs("reset");
    check_val("reset_chg", seq_changed, 0);
    check_val("reset_sat_seq", seq_num2, 0);
    check_val("reset_sat_leds", LEDS2, 1);
    pb_seq_dn = 1'b0;
    @(negedge clk_50) reset = 1'b1;
    press(1'b1, 1'b0);
    check_val("one_press_after_reset", pulse1, 1);

    // Bounce: runs of 3 samples never qualify, then a steady hold
    for (int i = 0; i < 40; i++) begin
      pb_seq_up = ((i / 3) % 2 == 0);
      settle();
      stick();
    end
    check_val("bounce_no_change", seq_num, 1);
    press(1'b1, 1'b0);
    check_val("bounce_one_pulse", pulse1, 2);

    // Step wrap and ROM address
    steps(17);
    check_outs("step17");
    check_val("rom_33", ROM_addr, 33);

    // Up press landing on the same edge as step_tick at step 5
    steps(4);
    check_val("step_is_5", step, 5);
    pb_seq_up = 1'b1;
    exp_q.push_back(3);
    n_push++;
    settle();
    sticks(7);
    @(negedge clk_50) sample_tick = 1'b1;
    @(negedge clk_50) begin sample_tick = 1'b0; step_tick = 1'b1; end
    @(negedge clk_50) step_tick = 1'b0;
    exp_step2 = (exp_step2 + 1) % 16;
    repeat (2) @(negedge clk_50);
    exp_seq = 3;
    exp_step = 0;
    check_outs("coincident");
    release_all();

    // Simultaneous up and down: no change, step kept
    steps(2);
    press(1'b1, 1'b1);
    check_val("simul_step_kept", step, 2);

    // Down, up to the top, wrap up, wrap down
    press(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    check_val("at_top", seq_num, 7);
    press(1'b1, 1'b0);
    check_val("wrap_up_leds", LEDS, 1);
    press(1'b0, 1'b1);
    check_val("wrap_dn_seq", seq_num, 7);

    // Saturating instance: down at 0 holds, no pulse, step untouched
    check_val("sat_step_pre", step2, exp_step2);
    pb_dn2 = 1'b1;
    settle();
    sticks(8);
    repeat (2) @(negedge clk_50);
    check_val("sat_seq", seq_num2, 0);
    check_val("sat_step", step2, exp_step2);
    check_val("sat_no_pulse", pulse2, 0);
    pb_dn2 = 1'b0;
    settle();
    sticks(8);

    // Reset 3 samples into a qualifying press at step 9
    steps(9);
    check_val("step_is_9", step, 9);
    pb_seq_up = 1'b1;
    settle();
    sticks(3);
    @(negedge clk_50) reset = 1'b0;
    #1;
    exp_seq = 0;
    exp_step = 0;
    exp_step2 = 0;
    check_outs("midreset");
    check_val("midreset_chg", seq_changed, 0);
    check_val("midreset_sat_step", step2, 0);
    repeat (3) @(negedge clk_50);
    reset = 1'b1;
    press(1'b1, 1'b0);

    check_val("queue_empty", exp_q.size(), 0);
    check_val("pulse_count", pulse1, n_push);
    check_val("sat_pulse_count", pulse2, 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
